// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory block: access sizes and FSM states.
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Request sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // True when the size is reserved or the low address bits break natural alignment
    function automatic logic size_align_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction with zero/sign extension, and store
// merge of right-justified data into the addressed lanes of a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] ld_data,
    output logic [31:0] st_word,
    output logic        size_err
);

    logic [4:0]  lane_shift;
    logic [31:0] rshifted;
    logic [31:0] lane_mask;
    logic [31:0] wshifted;

    // Select the addressed lane(s) of the read word and extend to 32 bits
    always_comb begin
        lane_shift = {addr_lo, 3'b000};
        rshifted   = rword >> lane_shift;
        ld_data    = 32'h0;
        case (size)
            SZ_BYTE: ld_data = {{24{sign_ext & rshifted[7]}}, rshifted[7:0]};
            SZ_HALF: ld_data = {{16{sign_ext & rshifted[15]}}, rshifted[15:0]};
            SZ_WORD: ld_data = rword;
            default: ld_data = 32'h0;
        endcase
    end

    // Move store data into its lanes and keep the untouched lanes of the old word
    always_comb begin
        lane_mask = 32'h0;
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF << lane_shift;
            SZ_HALF: lane_mask = 32'h0000_FFFF << lane_shift;
            SZ_WORD: lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0;
        endcase
        wshifted = wdata << lane_shift;
        st_word  = (rword & ~lane_mask) | (wshifted & lane_mask);
        size_err = size_align_err(size, addr_lo);
    end

endmodule

// File: rtl/lsu_mem.sv
// Single-port word memory behind a valid/ready load/store interface with a
// fixed, parameterised response latency.
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge.
// req_ready is high only in IDLE, so one request is in flight at a time and
// the response is held in RESP until the consumer takes it.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1,
    parameter int AW      = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output state_e        dbg_state
);

    localparam int            IW        = $clog2(DEPTH);
    localparam logic          LAT_ONE   = (LATENCY == 1);
    localparam logic [3:0]    CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [AW-3:0] WORD_LIMIT = (AW - 2)'(DEPTH);

    // Word storage; deliberately not reset
    logic [31:0] memory [DEPTH];

    state_e        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_signed;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_wdata;

    logic          accept;
    logic          commit;
    logic          act_we;
    logic [1:0]    act_size;
    logic          act_signed;
    logic [AW-1:0] act_addr;
    logic [31:0]   act_wdata;
    logic [IW-1:0] word_idx;
    logic [31:0]   rword;
    logic [31:0]   ld_data;
    logic [31:0]   st_word;
    logic          size_err;
    logic          range_err;
    logic          err;

    // Ready only in IDLE and never while reset is held, so nothing is accepted under reset
    assign req_ready = (state == ST_IDLE) && RST_N;
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // The request being completed: live inputs on a single-cycle accept, captured copy otherwise
    always_comb begin
        act_we     = cap_we;
        act_size   = cap_size;
        act_signed = cap_signed;
        act_addr   = cap_addr;
        act_wdata  = cap_wdata;
        if (state == ST_IDLE) begin
            act_we     = req_we;
            act_size   = req_size;
            act_signed = req_signed;
            act_addr   = req_addr;
            act_wdata  = req_wdata;
        end
    end

    // Word index, range check, and the edge on which the access actually happens
    always_comb begin
        word_idx  = act_addr[IW+1:2];
        rword     = memory[word_idx];
        range_err = (act_addr[AW-1:2] >= WORD_LIMIT);
        err       = size_err | range_err;
        commit    = ((state == ST_IDLE) && accept && LAT_ONE) ||
                    ((state == ST_WAIT) && (cnt == 4'd1));
    end

    lsu_lane_align u_align (
        .size     (act_size),
        .sign_ext (act_signed),
        .addr_lo  (act_addr[1:0]),
        .wdata    (act_wdata),
        .rword    (rword),
        .ld_data  (ld_data),
        .st_word  (st_word),
        .size_err (size_err)
    );

    // Commit a good store into only its addressed lanes on the transition into RESP
    always_ff @(posedge CLK) begin
        if (commit && act_we && !err) begin
            memory[word_idx] <= st_word;
        end
    end

    // Request sequencing FSM with registered response outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_signed <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cap_we     <= req_we;
                        cap_size   <= req_size;
                        cap_signed <= req_signed;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        if (LAT_ONE) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                            rsp_rdata <= (act_we || err) ? 32'h0 : ld_data;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (act_we || err) ? 32'h0 : ld_data;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= 4'd0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule
